// File: rtl/instr_loader_if.sv
// rtl/instr_loader_if.sv - host byte stream in, instruction memory word writes out
interface instr_loader_if;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;

    // master is the loader side: it drives the memory write port and the stream ready
    modport master (
        input  byte_valid, byte_data,
        output byte_ready, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        output byte_valid, byte_data,
        input  byte_ready, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/instr_loader.sv
// rtl/instr_loader.sv - byte stream to instruction memory loader holding the CPU in reset
// INSTR_LOADER_CHECKSUM_EN adds a trailing XOR checksum byte over count and data bytes
module instr_loader #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          MAX_WORDS = 256
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    instr_loader_if.master bus,
    output logic          cpu_hold,
    output logic          busy,
    output logic          done,
    output logic          err
);

    localparam logic [8:0] MAX_W = 9'(MAX_WORDS);

    typedef enum logic [2:0] {
        st_idle,
        st_hdr,
        st_data,
        st_write,
`ifdef INSTR_LOADER_CHECKSUM_EN
        st_check,
`endif
        st_done
    } state_t;

    state_t      state, state_nxt;
    logic [1:0]  byte_cnt;
    logic [8:0]  word_idx;
    logic [8:0]  word_total;
    logic [23:0] word_buf;
    logic        xfer;
    logic        can_start;
    logic [8:0]  hdr_count;
    logic        hdr_over;
    logic        last_word;
`ifdef INSTR_LOADER_CHECKSUM_EN
    logic [7:0]  csum;
`endif

    assign xfer      = bus.byte_valid && bus.byte_ready;
    assign can_start = start && (state == st_idle || state == st_done);
    // a count byte of zero stands for a full 256-word image
    assign hdr_count = (bus.byte_data == 8'd0) ? 9'd256 : {1'b0, bus.byte_data};
    assign hdr_over  = hdr_count > MAX_W;
    assign last_word = (word_idx + 9'd1) == word_total;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= st_idle;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            st_idle, st_done: if (start) state_nxt = st_hdr;
            st_hdr:           if (xfer) state_nxt = hdr_over ? st_done : st_data;
            st_data:          if (xfer && byte_cnt == 2'd3) state_nxt = st_write;
            st_write: begin
                if (last_word) begin
`ifdef INSTR_LOADER_CHECKSUM_EN
                    state_nxt = st_check;
`else
                    state_nxt = st_done;
`endif
                end else begin
                    state_nxt = st_data;
                end
            end
`ifdef INSTR_LOADER_CHECKSUM_EN
            st_check:         if (xfer) state_nxt = st_done;
`endif
            default:          state_nxt = st_idle;
        endcase
    end

    always_comb begin
        bus.byte_ready = 1'b0;
        bus.mem_we     = 1'b0;
        busy           = 1'b0;
        done           = 1'b0;
        cpu_hold       = 1'b1;
        case (state)
            st_hdr, st_data: begin
                bus.byte_ready = 1'b1;
                busy           = 1'b1;
            end
            st_write: begin
                bus.mem_we = 1'b1;
                busy       = 1'b1;
            end
`ifdef INSTR_LOADER_CHECKSUM_EN
            st_check: begin
                bus.byte_ready = 1'b1;
                busy           = 1'b1;
            end
`endif
            st_done: begin
                done     = !err;
                cpu_hold = err;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err           <= 1'b0;
            byte_cnt      <= 2'd0;
            word_idx      <= 9'd0;
            word_total    <= 9'd0;
            word_buf      <= 24'd0;
            bus.mem_addr  <= BASE_ADDR;
            bus.mem_wdata <= 32'd0;
`ifdef INSTR_LOADER_CHECKSUM_EN
            csum          <= 8'd0;
`endif
        end else begin
            if (can_start) begin
                err      <= 1'b0;
                byte_cnt <= 2'd0;
                word_idx <= 9'd0;
`ifdef INSTR_LOADER_CHECKSUM_EN
                csum     <= 8'd0;
`endif
            end
            if (state == st_hdr && xfer) begin
                if (hdr_over) begin
                    err <= 1'b1;
                end else begin
                    word_total <= hdr_count;
                end
                word_idx <= 9'd0;
`ifdef INSTR_LOADER_CHECKSUM_EN
                csum     <= csum ^ bus.byte_data;
`endif
            end
            if (state == st_data && xfer) begin
                word_buf <= {word_buf[15:0], bus.byte_data};
                byte_cnt <= byte_cnt + 2'd1;
`ifdef INSTR_LOADER_CHECKSUM_EN
                csum     <= csum ^ bus.byte_data;
`endif
                // address and data are staged so they are valid throughout the WRITE cycle
                if (byte_cnt == 2'd3) begin
                    bus.mem_addr  <= BASE_ADDR + {21'd0, word_idx, 2'b00};
                    bus.mem_wdata <= {word_buf, bus.byte_data};
                end
            end
            if (state == st_write) begin
                word_idx <= word_idx + 9'd1;
            end
`ifdef INSTR_LOADER_CHECKSUM_EN
            if (state == st_check && xfer && bus.byte_data != csum) begin
                err <= 1'b1;
            end
`endif
        end
    end

endmodule

// File: tb/tb_instr_loader.sv
// tb/tb_instr_loader.sv - self-checking bench for instr_loader
module tb_instr_loader;
    localparam logic [31:0] BASE = 32'h0000_0040;
    localparam int          MAXW = 16;
`ifdef INSTR_LOADER_CHECKSUM_EN
    localparam bit CSUM_EN = 1'b1;
`else
    localparam bit CSUM_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic cpu_hold, busy, done, err;

    instr_loader_if bus();

    instr_loader #(.BASE_ADDR(BASE), .MAX_WORDS(MAXW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .bus(bus),
        .cpu_hold(cpu_hold), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] cnt;
        bit         gappy;
        bit         exp_err;
        bit         exp_done;
        bit         exp_hold;
    } vec_t;

    int          n_cmp = 0;
    int          n_fail = 0;
    int          viol = 0;
    logic [63:0] obs_q[$];
    logic [31:0] img[256];
    bit          prev_xfer = 1'b0;
    bit          prev_we = 1'b0;
    vec_t        vecs[8];

    // observe writes between edges; a write must follow an accepted byte and never overlap ready
    always @(negedge clk) begin
        #2;
        if (!rst_n) begin
            prev_xfer = 1'b0;
            prev_we   = 1'b0;
        end else begin
            if (bus.mem_we) begin
                obs_q.push_back({bus.mem_addr, bus.mem_wdata});
                if (bus.byte_ready || !prev_xfer || prev_we) viol++;
            end
            prev_we   = bus.mem_we;
            prev_xfer = bus.byte_valid && bus.byte_ready;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gappy);
        int t;
        bit sent;
        t = 0;
        sent = 1'b0;
        while (!sent && t < 200) begin
            if (gappy && $urandom_range(0, 1) == 1) begin
                bus.byte_valid = 1'b0;
                bus.byte_data  = 8'($urandom);
            end else begin
                bus.byte_valid = 1'b1;
                bus.byte_data  = b;
                sent = bus.byte_ready;
            end
            @(negedge clk);
            t++;
        end
        bus.byte_valid = 1'b0;
        check("send_timeout", 32'(sent), 32'd1);
    endtask

    task automatic send_word(input logic [31:0] w, input bit gappy, inout logic [7:0] x);
        for (int b = 0; b < 4; b++) begin
            x = x ^ w[31-8*b -: 8];
            send_byte(w[31-8*b -: 8], gappy);
        end
    endtask

    task automatic wait_idle(input string tag);
        int t;
        t = 0;
        while (busy && t < 50) begin
            @(negedge clk);
            t++;
        end
        check({tag, " timeout"}, 32'(busy), 32'd0);
    endtask

    task automatic check_writes(input string tag, input int exp_n);
        logic [63:0] e;
        check({tag, " nwrites"}, 32'(obs_q.size()), 32'(exp_n));
        for (int i = 0; i < exp_n && i < obs_q.size(); i++) begin
            e = {BASE + 32'(4 * i), img[i]};
            check({tag, " waddr"}, obs_q[i][63:32], e[63:32]);
            check({tag, " wdata"}, obs_q[i][31:0], e[31:0]);
        end
    endtask

    // reference: N words go to BASE+4i unless N (0 meaning 256) exceeds capacity
    task automatic run_load(input logic [7:0] cnt, input bit gappy, input logic [7:0] csum_mask,
                            input bit exp_err, input bit exp_done, input bit exp_hold,
                            input string tag);
        int n;
        bit over;
        logic [7:0] x;
        n = (cnt == 8'd0) ? 256 : int'(cnt);
        over = n > MAXW;
        obs_q.delete();
        pulse_start();
        check({tag, " busy"}, 32'(busy), 32'd1);
        x = cnt;
        send_byte(cnt, gappy);
        if (!over) begin
            for (int i = 0; i < n; i++) send_word(img[i], gappy, x);
            if (CSUM_EN) send_byte(x ^ csum_mask, gappy);
        end
        wait_idle(tag);
        check_writes(tag, over ? 0 : n);
        check({tag, " done"}, 32'(done), 32'(exp_done));
        check({tag, " err"}, 32'(err), 32'(exp_err));
        check({tag, " hold"}, 32'(cpu_hold), 32'(exp_hold));
        check({tag, " ready"}, 32'(bus.byte_ready), 32'd0);
        if (!over) check({tag, " addr_hold"}, bus.mem_addr, BASE + 32'(4 * (n - 1)));
    endtask

    initial begin
        logic [7:0] x;
        logic [7:0] cnt;
        logic [7:0] mask;
        bit         bad;
        bus.byte_valid = 1'b0;
        bus.byte_data  = 8'd0;
        vecs = '{
            '{8'h01, 1'b0, 1'b0, 1'b1, 1'b0},
            '{8'h10, 1'b1, 1'b0, 1'b1, 1'b0},
            '{8'h11, 1'b0, 1'b1, 1'b0, 1'b1},
            '{8'h01, 1'b0, 1'b0, 1'b1, 1'b0},
            '{8'h00, 1'b0, 1'b1, 1'b0, 1'b1},
            '{8'h03, 1'b1, 1'b0, 1'b1, 1'b0},
            '{8'hFF, 1'b1, 1'b1, 1'b0, 1'b1},
            '{8'h02, 1'b1, 1'b0, 1'b1, 1'b0}
        };

        repeat (2) @(negedge clk);
        check("rst ready", 32'(bus.byte_ready), 32'd0);
        check("rst we", 32'(bus.mem_we), 32'd0);
        check("rst busy", 32'(busy), 32'd0);
        check("rst done", 32'(done), 32'd0);
        check("rst err", 32'(err), 32'd0);
        check("rst hold", 32'(cpu_hold), 32'd1);
        check("rst addr", bus.mem_addr, BASE);
        check("rst wdata", bus.mem_wdata, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        img[0] = 32'h8C01_0000;
        img[1] = 32'h8C02_0004;
        run_load(8'h02, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, "two_word");
        run_load(8'h02, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0, "gapped");

        obs_q.delete();
        pulse_start();
        x = 8'h02;
        send_byte(8'h02, 1'b0);
        send_word(img[0], 1'b0, x);
        pulse_start();
        send_word(img[1], 1'b1, x);
        if (CSUM_EN) send_byte(x, 1'b0);
        wait_idle("start_busy");
        check_writes("start_busy", 2);
        check("start_busy done", 32'(done), 32'd1);

        obs_q.delete();
        pulse_start();
        send_byte(8'h02, 1'b0);
        send_byte(8'h8C, 1'b0);
        send_byte(8'h01, 1'b0);
        #3 rst_n = 1'b0;
        #1;
        check("midrst busy", 32'(busy), 32'd0);
        check("midrst hold", 32'(cpu_hold), 32'd1);
        check("midrst ready", 32'(bus.byte_ready), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("midrst nwrites", 32'(obs_q.size()), 32'd0);
        check("midrst idle_ready", 32'(bus.byte_ready), 32'd0);
        check("midrst idle_hold", 32'(cpu_hold), 32'd1);
        check("midrst addr", bus.mem_addr, BASE);

        for (int v = 0; v < 8; v++) begin
            for (int i = 0; i < MAXW; i++) img[i] = $urandom;
            run_load(vecs[v].cnt, vecs[v].gappy, 8'h00, vecs[v].exp_err,
                     vecs[v].exp_done, vecs[v].exp_hold, "table");
        end

        for (int k = 0; k < 8; k++) begin
            for (int i = 0; i < MAXW; i++) img[i] = $urandom;
            cnt  = 8'($urandom_range(0, 20));
            mask = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
            bad  = (cnt == 8'd0) || (int'(cnt) > MAXW) || (CSUM_EN && mask != 8'h00);
            run_load(cnt, 1'($urandom_range(0, 1)), mask, bad, !bad, bad, "rand");
        end

`ifdef INSTR_LOADER_CHECKSUM_EN
        img[0] = 32'h0022_1820;
        run_load(8'h01, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, "csum_ok");
        run_load(8'h01, 1'b0, 8'h07, 1'b1, 1'b0, 1'b1, "csum_bad");
`endif

        check("protocol", 32'(viol), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
